bf_data_unit: RTL and testbench
===============================

# bf_data_unit

Data-path execution unit of the Brainfuck CPU, sitting directly upstream of the data-memory controller. It executes the data-side instructions (`+ - > < . ,`) handed over by the instruction decoder. It holds the data pointer and a one-cell write-back cache of the current cell. It drives the memory controller's level-held `RD`/`WD` strobes and waits on its `RF`/`WF` completion flags, so most `+`/`-` runs never touch memory.

## Interface
- `DP_W`, 15: data pointer width; memory depth is 2**DP_W cells.
- `TIMEOUT`, 255: maximum cycles to wait for `RF`/`WF` before aborting an access (range 1..65535).
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered by the decoder.
- `cmd_op`  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 OUT, 6 IN, 7 FLUSH.
- `cmd_data`  in  8  input byte for IN; ignored otherwise.
- `cmd_ready`  out  1  unit is IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_done`  out  1  one-cycle pulse when the accepted command completes.
- `cell_val`  out  8  cached current-cell value; meaningful when `cell_vld`=1.
- `cell_vld`  out  1  cache holds the cell at `DP`.
- `cell_zero`  out  1  `cell_vld && cell_val==0`, used for `[`/`]` decisions.
- `err`  out  1  sticky; set on any access timeout, cleared only by reset.
- `RD`  out  1  read strobe to the memory controller.
- `WD`  out  1  write strobe to the memory controller.
- `DP`  out  DP_W  data pointer / memory address.
- `WDATA`  out  8  write data.
- `RF`  in  1  read-complete flag.
- `WF`  in  1  write-complete flag.
- `RDATA`  in  8  read data; valid when `RF` is sampled high.

## Operation
- States: IDLE, WB (write-back), RDQ (read), GAP.
- Reset values: IDLE, `DP`=0, `cell_val`=0, `cell_vld`=0, dirty=0, `RD`=`WD`=0, `WDATA`=0, `cmd_done`=0, `err`=0, `cmd_ready`=1.
- IDLE, accept cases:
  - NOP: done.
  - INC/DEC hit (`cell_vld`=1): `cell_val`±1 mod 256, dirty=1, done.
  - INC/DEC/OUT miss (`cell_vld`=0): go to RDQ, then apply the op on `RDATA`; OUT sets no dirty.
  - OUT hit: done with no change.
  - IN: `cell_val`=`cmd_data`, `cell_vld`=1, dirty=1, done; no read is issued.
  - RIGHT/LEFT: if dirty, go to WB first. Then `DP`±1 mod 2**DP_W (wraps 2**DP_W-1↔0), `cell_vld`=0, done. No read is issued; reads are lazy.
  - FLUSH: if dirty, go to WB, then done; otherwise done immediately.
- WB: `WDATA`=`cell_val`, `WD`=1 held until `WF` is sampled high, then dirty=0. Go to GAP, then finish the pending op.
- RDQ: `RD`=1 held until `RF` is sampled high. On that edge: `cell_val`=`RDATA`±op, `cell_vld`=1.
- GAP: one cycle with both strobes low. It guarantees a fresh rising edge on the next access.
- `RD` and `WD` are never high together. `DP` and `WDATA` are stable for the whole strobe.
- Timeout: a wait counter starts on strobe assertion. On reaching `TIMEOUT` without the flag:
  - the strobe drops and `err`=1;
  - the command completes with `cmd_done`;
  - cache state is left unchanged (miss stays invalid; dirty stays set).
- Reset mid-access: the strobe drops asynchronously. The dirty cell is lost, and this is accepted behaviour.
- `cmd_valid` is ignored outside IDLE. The decoder holds `cmd_op`/`cmd_data` only for the accept cycle, and the unit latches both.

## Timing
- Accept at edge t.
- Hit INC/DEC/OUT/IN/NOP/clean move/clean FLUSH: `cmd_done` high in cycle t+1; `cmd_ready` stays 1; back-to-back accepts are possible every cycle.
- Miss: `RD` rises in cycle t+1. `RF` is sampled high at edge t+k. Then `RD`=0, GAP follows, `cmd_done` is high in cycle t+k+1, and `cmd_ready` returns in cycle t+k+2.
- Dirty move: `WD` rises in cycle t+1 and `WF` is sampled at edge t+k. `DP` changes and `cmd_done` are high in cycle t+k+1.
- `cell_zero` and `cell_val` are valid in the `cmd_done` cycle.
- `RF`/`WF` are treated as synchronous inputs at least one `clk` high. A flag sampled while no strobe is pending is ignored.

## Test plan
- Reset, then INC×3 on cell 0 with memory holding 0x05: one read at `DP`=0. `cell_val`=0x08 after the third done, and the last two INCs complete in 1 cycle each.
- `cell_val`=0x02 dirty, then RIGHT: `WD` pulse with `DP`=0, `WDATA`=0x02, then `DP`=1, `cell_vld`=0, no `RD`.
- LEFT from `DP`=0 → `DP`=0x7FFF. INC with `cell_val`=0xFF → 0x00 and `cell_zero`=1.
- IN 0x41 then OUT: no memory access at all, and `cell_val`=0x41 on the OUT done.
- `TIMEOUT`=4, `RF` never asserted on a read: `RD` drops after 4 cycles, `err`=1, `cmd_done` pulses, `cell_vld` stays 0.
- `rst_n` pulled low mid-WB: `WD`=0 immediately, and all outputs return to their reset values.

Source files
------------

// File: rtl/bf_data_if.sv
// Bundle of the decoder-side command handshake and the memory-controller strobes
// for the Brainfuck data unit. "slave" is the unit's view, "master" the environment's.
interface bf_data_if #(
   parameter int DP_W = 15
);
   logic            cmd_valid;
   logic [2:0]      cmd_op;
   logic [7:0]      cmd_data;
   logic            cmd_ready;
   logic            cmd_done;
   logic [7:0]      cell_val;
   logic            cell_vld;
   logic            cell_zero;
   logic            err;
   logic            RD;
   logic            WD;
   logic [DP_W-1:0] DP;
   logic [7:0]      WDATA;
   logic            RF;
   logic            WF;
   logic [7:0]      RDATA;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, RF, WF, RDATA,
      output cmd_ready, cmd_done, cell_val, cell_vld, cell_zero, err,
             RD, WD, DP, WDATA
   );

   modport master (
      output cmd_valid, cmd_op, cmd_data, RF, WF, RDATA,
      input  cmd_ready, cmd_done, cell_val, cell_vld, cell_zero, err,
             RD, WD, DP, WDATA
   );
endinterface

// File: rtl/bf_data_unit.sv
// Data-side execution unit: data pointer plus a one-cell write-back cache in front of
// the data-memory controller, with lazy reads and bounded waits on RF/WF.
module bf_data_unit #(
   parameter int DP_W    = 15,
   parameter int TIMEOUT = 255
) (
   input  logic     clk,
   input  logic     rst_n,
   bf_data_if.slave bus
);
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_INC   = 3'd1;
   localparam logic [2:0] OP_DEC   = 3'd2;
   localparam logic [2:0] OP_RIGHT = 3'd3;
   localparam logic [2:0] OP_LEFT  = 3'd4;
   localparam logic [2:0] OP_OUT   = 3'd5;
   localparam logic [2:0] OP_IN    = 3'd6;
   localparam logic [2:0] OP_FLUSH = 3'd7;

   // Counter starts at 0 on the edge that raises the strobe, so the strobe is high
   // for exactly TIMEOUT cycles when the flag never arrives.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WB, RDQ, GAP} state_t;

   state_t          state_reg;
   logic [2:0]      op_reg;
   logic [DP_W-1:0] dp_reg;
   logic [7:0]      cell_val_reg;
   logic            cell_vld_reg;
   logic            dirty_reg;
   logic            rd_reg;
   logic            wd_reg;
   logic [7:0]      wdata_reg;
   logic            done_reg;
   logic            err_reg;
   logic [15:0]     wait_cnt_reg;

   function automatic logic [7:0] apply_op(input logic [2:0] op, input logic [7:0] v);
      if (op == OP_INC) return v + 8'd1;
      if (op == OP_DEC) return v - 8'd1;
      return v;
   endfunction

   function automatic logic [DP_W-1:0] move_dp(input logic [2:0] op, input logic [DP_W-1:0] dp);
      return (op == OP_LEFT) ? dp - DP_W'(1) : dp + DP_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         op_reg       <= OP_NOP;
         dp_reg       <= '0;
         cell_val_reg <= '0;
         cell_vld_reg <= 1'b0;
         dirty_reg    <= 1'b0;
         rd_reg       <= 1'b0;
         wd_reg       <= 1'b0;
         wdata_reg    <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.cmd_valid) begin
                  op_reg       <= bus.cmd_op;
                  wait_cnt_reg <= '0;
                  case (bus.cmd_op)
                     OP_INC, OP_DEC, OP_OUT: begin
                        if (cell_vld_reg) begin
                           cell_val_reg <= apply_op(bus.cmd_op, cell_val_reg);
                           if (bus.cmd_op != OP_OUT) dirty_reg <= 1'b1;
                           done_reg <= 1'b1;
                        end else begin
                           rd_reg    <= 1'b1;
                           state_reg <= RDQ;
                        end
                     end
                     OP_IN: begin
                        cell_val_reg <= bus.cmd_data;
                        cell_vld_reg <= 1'b1;
                        dirty_reg    <= 1'b1;
                        done_reg     <= 1'b1;
                     end
                     OP_RIGHT, OP_LEFT, OP_FLUSH: begin
                        if (dirty_reg) begin
                           wd_reg    <= 1'b1;
                           wdata_reg <= cell_val_reg;
                           state_reg <= WB;
                        end else begin
                           if (bus.cmd_op != OP_FLUSH) begin
                              dp_reg       <= move_dp(bus.cmd_op, dp_reg);
                              cell_vld_reg <= 1'b0;
                           end
                           done_reg <= 1'b1;
                        end
                     end
                     default: done_reg <= 1'b1;
                  endcase
               end
            end
            WB: begin
               // The pending move completes on the WF edge; GAP only spaces the strobes.
               if (bus.WF) begin
                  wd_reg    <= 1'b0;
                  dirty_reg <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= GAP;
                  if (op_reg != OP_FLUSH) begin
                     dp_reg       <= move_dp(op_reg, dp_reg);
                     cell_vld_reg <= 1'b0;
                  end
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  wd_reg    <= 1'b0;
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= GAP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
               end
            end
            RDQ: begin
               if (bus.RF) begin
                  rd_reg       <= 1'b0;
                  cell_val_reg <= apply_op(op_reg, bus.RDATA);
                  cell_vld_reg <= 1'b1;
                  if (op_reg != OP_OUT) dirty_reg <= 1'b1;
                  done_reg     <= 1'b1;
                  state_reg    <= GAP;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  rd_reg    <= 1'b0;
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= GAP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
               end
            end
            GAP:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.cmd_done  = done_reg;
   assign bus.cell_val  = cell_val_reg;
   assign bus.cell_vld  = cell_vld_reg;
   assign bus.cell_zero = cell_vld_reg && (cell_val_reg == 8'd0);
   assign bus.err       = err_reg;
   assign bus.RD        = rd_reg;
   assign bus.WD        = wd_reg;
   assign bus.DP        = dp_reg;
   assign bus.WDATA     = wdata_reg;
endmodule

// File: tb/tb_bf_data_unit.sv
// Bench for bf_data_unit: directed vector table, randomized commands against a
// logical-memory model, then timeout and asynchronous-reset corner sequences.
module tb_bf_data_unit;
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_INC   = 3'd1;
   localparam logic [2:0] OP_DEC   = 3'd2;
   localparam logic [2:0] OP_RIGHT = 3'd3;
   localparam logic [2:0] OP_LEFT  = 3'd4;
   localparam logic [2:0] OP_OUT   = 3'd5;
   localparam logic [2:0] OP_IN    = 3'd6;
   localparam logic [2:0] OP_FLUSH = 3'd7;
   localparam int NCELL = 32768;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bf_data_if #(.DP_W(15)) bus ();
   bf_data_unit #(.DP_W(15), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_pass = 0;

   // Memory-controller model state (written only by the responder process)
   logic [7:0]  mem [0:NCELL-1];
   int          rd_count = 0, wr_count = 0, rd_high = 0, prot_err = 0;
   logic [14:0] last_waddr = '0;
   logic [7:0]  last_wdata = '0;
   bit          resp_en = 1'b1;
   bit          wr_stall = 1'b0;

   // Reference model: logical memory as the program sees it
   logic [7:0]  lmem [0:NCELL-1];
   logic [14:0] m_dp;
   bit          m_vld, m_dirty;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  data;
      logic [7:0]  val;
      logic        vld;
      logic [14:0] dp;
      int          rds;
      int          wrs;
      logic [14:0] waddr;
      logic [7:0]  wdata;
   } vec_t;
   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   initial begin : responder
      int rd_wait, wr_wait, rd_lat, wr_lat;
      bit prev_strobe;
      logic [14:0] prev_dp;
      logic [7:0]  prev_wdata;
      rd_wait = 0; wr_wait = 0; rd_lat = 1; wr_lat = 1;
      prev_strobe = 1'b0; prev_dp = '0; prev_wdata = '0;
      for (int i = 0; i < NCELL; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h05;
      mem[1] = 8'h00;
      mem[NCELL-1] = 8'hFF;
      bus.RF = 1'b0; bus.WF = 1'b0; bus.RDATA = '0;
      forever begin
         @(negedge clk);
         bus.RF = 1'b0;
         bus.WF = 1'b0;
         bus.RDATA = 8'($urandom);
         if (bus.RD && bus.WD) prot_err++;
         if (prev_strobe && (bus.RD || bus.WD) &&
             (bus.DP != prev_dp || (bus.WD && bus.WDATA != prev_wdata))) prot_err++;
         prev_strobe = bus.RD || bus.WD;
         prev_dp = bus.DP;
         prev_wdata = bus.WDATA;
         if (bus.RD) begin
            rd_high++;
            if (rd_wait == 0) rd_lat = int'($urandom_range(1, 3));
            rd_wait++;
            if (resp_en && rd_wait >= rd_lat) begin
               bus.RF = 1'b1;
               bus.RDATA = mem[bus.DP];
               rd_count++;
               rd_wait = 0;
            end
         end else rd_wait = 0;
         if (bus.WD) begin
            if (wr_wait == 0) wr_lat = int'($urandom_range(1, 3));
            wr_wait++;
            if (!wr_stall && wr_wait >= wr_lat) begin
               bus.WF = 1'b1;
               mem[bus.DP] = bus.WDATA;
               last_waddr = bus.DP;
               last_wdata = bus.WDATA;
               wr_count++;
               wr_wait = 0;
            end
         end else wr_wait = 0;
      end
   end

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, output int cyc);
      int guard;
      guard = 0;
      while (!bus.cmd_ready && guard < 200) begin @(negedge clk); guard++; end
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_data = d;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'($urandom);
      bus.cmd_data = 8'($urandom);
      cyc = 1;
      while (!bus.cmd_done && cyc < 300) begin @(posedge clk); #1; cyc++; end
      if (!bus.cmd_done) begin
         n_chk++;
         $display("FAIL done_wait: got no cmd_done within %0d cycles, expected a pulse", cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_step(input logic [2:0] op, input logic [7:0] d, input int idx);
      int r0, w0, cyc, er, ew;
      logic [14:0] odp;
      r0 = rd_count; w0 = wr_count; odp = m_dp; er = 0; ew = 0;
      case (op)
         OP_INC, OP_DEC: begin
            er = m_vld ? 0 : 1;
            lmem[m_dp] = (op == OP_INC) ? lmem[m_dp] + 8'd1 : lmem[m_dp] - 8'd1;
            m_vld = 1'b1; m_dirty = 1'b1;
         end
         OP_OUT: begin er = m_vld ? 0 : 1; m_vld = 1'b1; end
         OP_IN:  begin lmem[m_dp] = d; m_vld = 1'b1; m_dirty = 1'b1; end
         OP_RIGHT, OP_LEFT: begin
            ew = m_dirty ? 1 : 0;
            m_dirty = 1'b0; m_vld = 1'b0;
            m_dp = (op == OP_RIGHT) ? m_dp + 15'd1 : m_dp - 15'd1;
         end
         OP_FLUSH: begin ew = m_dirty ? 1 : 0; m_dirty = 1'b0; end
         default: ;
      endcase
      run_cmd(op, d, cyc);
      $display("rnd %0d op=%0d data=%02h dp=%04h val=%02h vld=%0d cyc=%0d",
               idx, op, d, bus.DP, bus.cell_val, bus.cell_vld, cyc);
      chk("rnd_dp", 32'(bus.DP), 32'(m_dp));
      chk("rnd_vld", 32'(bus.cell_vld), 32'(m_vld));
      if (m_vld) chk("rnd_val", 32'(bus.cell_val), 32'(lmem[m_dp]));
      chk("rnd_zero", 32'(bus.cell_zero), 32'(m_vld && lmem[m_dp] == 8'd0));
      chk("rnd_reads", 32'(rd_count - r0), 32'(er));
      chk("rnd_writes", 32'(wr_count - w0), 32'(ew));
      if (ew != 0) begin
         chk("rnd_waddr", 32'(last_waddr), 32'(odp));
         chk("rnd_wdata", 32'(last_wdata), 32'(lmem[odp]));
      end
      if (er == 0 && ew == 0) chk("rnd_latency", 32'(cyc), 32'd1);
   endtask

   initial begin : main
      int cyc, r0, w0, h0, bad;
      rst_n = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_data = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_done", 32'(bus.cmd_done), 32'd0);
      chk("rst_val", 32'(bus.cell_val), 32'd0);
      chk("rst_vld", 32'(bus.cell_vld), 32'd0);
      chk("rst_zero", 32'(bus.cell_zero), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_rd", 32'(bus.RD), 32'd0);
      chk("rst_wd", 32'(bus.WD), 32'd0);
      chk("rst_dp", 32'(bus.DP), 32'd0);
      chk("rst_wdata", 32'(bus.WDATA), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: mem[0]=05, mem[1]=00, mem[7FFF]=FF at start
      vecs[0]  = '{OP_INC,   8'h00, 8'h06, 1'b1, 15'h0000, 1, 0, 15'h0000, 8'h00};
      vecs[1]  = '{OP_INC,   8'h00, 8'h07, 1'b1, 15'h0000, 0, 0, 15'h0000, 8'h00};
      vecs[2]  = '{OP_INC,   8'h00, 8'h08, 1'b1, 15'h0000, 0, 0, 15'h0000, 8'h00};
      vecs[3]  = '{OP_IN,    8'h02, 8'h02, 1'b1, 15'h0000, 0, 0, 15'h0000, 8'h00};
      vecs[4]  = '{OP_RIGHT, 8'h00, 8'h00, 1'b0, 15'h0001, 0, 1, 15'h0000, 8'h02};
      vecs[5]  = '{OP_LEFT,  8'h00, 8'h00, 1'b0, 15'h0000, 0, 0, 15'h0000, 8'h00};
      vecs[6]  = '{OP_LEFT,  8'h00, 8'h00, 1'b0, 15'h7FFF, 0, 0, 15'h0000, 8'h00};
      vecs[7]  = '{OP_INC,   8'h00, 8'h00, 1'b1, 15'h7FFF, 1, 0, 15'h0000, 8'h00};
      vecs[8]  = '{OP_IN,    8'h41, 8'h41, 1'b1, 15'h7FFF, 0, 0, 15'h0000, 8'h00};
      vecs[9]  = '{OP_OUT,   8'h00, 8'h41, 1'b1, 15'h7FFF, 0, 0, 15'h0000, 8'h00};
      vecs[10] = '{OP_FLUSH, 8'h00, 8'h41, 1'b1, 15'h7FFF, 0, 1, 15'h7FFF, 8'h41};
      vecs[11] = '{OP_FLUSH, 8'h00, 8'h41, 1'b1, 15'h7FFF, 0, 0, 15'h0000, 8'h00};
      vecs[12] = '{OP_DEC,   8'h00, 8'h40, 1'b1, 15'h7FFF, 0, 0, 15'h0000, 8'h00};
      vecs[13] = '{OP_RIGHT, 8'h00, 8'h00, 1'b0, 15'h0000, 0, 1, 15'h7FFF, 8'h40};
      vecs[14] = '{OP_OUT,   8'h00, 8'h02, 1'b1, 15'h0000, 1, 0, 15'h0000, 8'h00};
      vecs[15] = '{OP_RIGHT, 8'h00, 8'h00, 1'b0, 15'h0001, 0, 0, 15'h0000, 8'h00};
      vecs[16] = '{OP_NOP,   8'h00, 8'h00, 1'b0, 15'h0001, 0, 0, 15'h0000, 8'h00};
      vecs[17] = '{OP_DEC,   8'h00, 8'hFF, 1'b1, 15'h0001, 1, 0, 15'h0000, 8'h00};
      for (int i = 0; i < 18; i++) begin
         r0 = rd_count; w0 = wr_count;
         run_cmd(vecs[i].op, vecs[i].data, cyc);
         $display("vec %0d op=%0d data=%02h dp=%04h val=%02h vld=%0d cyc=%0d",
                  i, vecs[i].op, vecs[i].data, bus.DP, bus.cell_val, bus.cell_vld, cyc);
         chk($sformatf("v%0d_vld", i), 32'(bus.cell_vld), 32'(vecs[i].vld));
         if (vecs[i].vld) chk($sformatf("v%0d_val", i), 32'(bus.cell_val), 32'(vecs[i].val));
         chk($sformatf("v%0d_zero", i), 32'(bus.cell_zero),
             32'(vecs[i].vld && vecs[i].val == 8'h00));
         chk($sformatf("v%0d_dp", i), 32'(bus.DP), 32'(vecs[i].dp));
         chk($sformatf("v%0d_reads", i), 32'(rd_count - r0), 32'(vecs[i].rds));
         chk($sformatf("v%0d_writes", i), 32'(wr_count - w0), 32'(vecs[i].wrs));
         if (vecs[i].wrs != 0) begin
            chk($sformatf("v%0d_waddr", i), 32'(last_waddr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].wdata));
         end
         if (vecs[i].rds == 0 && vecs[i].wrs == 0)
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd1);
      end

      // Randomized commands against the logical-memory model
      do_reset();
      for (int i = 0; i < NCELL; i++) lmem[i] = mem[i];
      m_dp = '0; m_vld = 1'b0; m_dirty = 1'b0;
      for (int i = 0; i < 300; i++)
         model_step(3'($urandom_range(0, 7)), 8'($urandom), i);
      model_step(OP_FLUSH, 8'h00, 300);
      bad = 0;
      for (int i = 0; i < NCELL; i++) if (mem[i] !== lmem[i]) bad++;
      chk("mem_image", 32'(bad), 32'd0);

      // Read timeout: RF withheld, TIMEOUT=4
      do_reset();
      chk("to_err_before", 32'(bus.err), 32'd0);
      resp_en = 1'b0;
      h0 = rd_high; r0 = rd_count;
      run_cmd(OP_INC, 8'h00, cyc);
      $display("timeout op=%0d cyc=%0d err=%0d vld=%0d", OP_INC, cyc, bus.err, bus.cell_vld);
      chk("to_latency", 32'(cyc), 32'd5);
      chk("to_err", 32'(bus.err), 32'd1);
      chk("to_vld", 32'(bus.cell_vld), 32'd0);
      chk("to_rd_low", 32'(bus.RD), 32'd0);
      @(negedge clk);
      chk("to_rd_cycles", 32'(rd_high - h0), 32'd4);
      chk("to_no_read", 32'(rd_count - r0), 32'd0);
      @(posedge clk); #1;
      chk("to_done_pulse", 32'(bus.cmd_done), 32'd0);
      chk("to_err_sticky", 32'(bus.err), 32'd1);
      resp_en = 1'b1;

      // Reset pulled mid write-back
      wr_stall = 1'b1;
      run_cmd(OP_IN, 8'h33, cyc);
      w0 = wr_count;
      while (!bus.cmd_ready) @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_RIGHT; bus.cmd_data = 8'h00;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      $display("midwb op=%0d wd=%0d wdata=%02h dp=%04h", OP_RIGHT, bus.WD, bus.WDATA, bus.DP);
      chk("wb_wd_high", 32'(bus.WD), 32'd1);
      chk("wb_wdata", 32'(bus.WDATA), 32'h33);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_wd", 32'(bus.WD), 32'd0);
      chk("arst_rd", 32'(bus.RD), 32'd0);
      chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("arst_done", 32'(bus.cmd_done), 32'd0);
      chk("arst_val", 32'(bus.cell_val), 32'd0);
      chk("arst_vld", 32'(bus.cell_vld), 32'd0);
      chk("arst_zero", 32'(bus.cell_zero), 32'd0);
      chk("arst_err", 32'(bus.err), 32'd0);
      chk("arst_dp", 32'(bus.DP), 32'd0);
      chk("arst_wdata", 32'(bus.WDATA), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_stall = 1'b0;
      chk("arst_no_write", 32'(wr_count - w0), 32'd0);
      repeat (2) @(negedge clk);
      chk("protocol", 32'(prot_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
